// File: rtl/ahb3lite_timer_irq.sv
// AHB3-lite timer bank: NUM_CH down-counters on a shared prescaler, level IRQ = PEND & IE.
// Zero wait states (HREADYOUT tied high); writes commit at the end of the data phase, reads are combinational.
module ahb3lite_timer_irq #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_CH-1:0]     IRQ
);

  logic                          dp_vld;
  logic                          dp_write;
  logic                          dp_word;
  logic [6:0]                    dp_addr;

  logic                          wr;
  logic                          rd;
  logic                          glob;
  logic [3:0]                    ch_sel;
  logic [1:0]                    reg_sel;
  logic                          prescale_wr;

  logic [15:0]                   prescale;
  logic [15:0]                   pre_cnt;
  logic                          tick;

  logic [NUM_CH-1:0]             en;
  logic [NUM_CH-1:0]             periodic;
  logic [NUM_CH-1:0]             ie;
  logic [NUM_CH-1:0]             pend;
  logic [NUM_CH-1:0][CNT_W-1:0]  load;
  logic [NUM_CH-1:0][CNT_W-1:0]  count;

  logic [NUM_CH-1:0]             ctrl_wr;
  logic [NUM_CH-1:0]             load_wr;
  logic [NUM_CH-1:0]             stat_wr;
  logic [NUM_CH-1:0]             term;
  logic [HDATA_SIZE-1:0]         rdata;

  logic                          unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:9], HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_vld   <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_word  <= (HSIZE == 3'b010);
      dp_addr  <= HADDR[8:2];
    end
  end

  // Sub-word writes are accepted on the bus but never touch a register.
  assign wr          = dp_vld & dp_write & dp_word & HREADY;
  assign rd          = dp_vld & ~dp_write;
  assign glob        = dp_addr[6];
  assign ch_sel      = dp_addr[5:2];
  assign reg_sel     = dp_addr[1:0];
  assign prescale_wr = wr & glob & (dp_addr[5:0] == 6'd0);

  assign tick = (pre_cnt == prescale) & ~prescale_wr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else if (prescale_wr) begin
      prescale <= HWDATA[15:0];
      pre_cnt  <= '0;
    end else if (pre_cnt == prescale) begin
      pre_cnt  <= '0;
    end else begin
      pre_cnt  <= pre_cnt + 16'd1;
    end
  end

  always_comb begin
    ctrl_wr = '0;
    load_wr = '0;
    stat_wr = '0;
    term    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && !glob && ch_sel == 4'(c)) begin
        ctrl_wr[c] = (reg_sel == 2'd0);
        load_wr[c] = (reg_sel == 2'd1);
        stat_wr[c] = (reg_sel == 2'd3);
      end
      term[c] = tick & en[c] & (count[c] == '0);
    end
  end

  // Priorities: a bus write to CTRL/LOAD overrides the hardware update; a PEND set beats W1C.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en       <= '0;
      periodic <= '0;
      ie       <= '0;
      pend     <= '0;
      load     <= '0;
      count    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_wr[c]) begin
          en[c]       <= HWDATA[0];
          periodic[c] <= HWDATA[1];
          ie[c]       <= HWDATA[2];
        end else if (term[c] && !periodic[c]) begin
          en[c] <= 1'b0;
        end

        pend[c] <= term[c] | (pend[c] & ~(stat_wr[c] & HWDATA[0]));

        if (load_wr[c]) begin
          load[c]  <= HWDATA[CNT_W-1:0];
          count[c] <= HWDATA[CNT_W-1:0];
        end else if (term[c]) begin
          if (periodic[c]) count[c] <= load[c];
        end else if (tick && en[c]) begin
          count[c] <= count[c] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (glob) begin
        if (dp_addr[5:0] == 6'd0)      rdata[15:0]       = prescale;
        else if (dp_addr[5:0] == 6'd1) rdata[NUM_CH-1:0] = pend;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel == 4'(c)) begin
            case (reg_sel)
              2'd0: rdata[2:0]       = {ie[c], periodic[c], en[c]};
              2'd1: rdata[CNT_W-1:0] = load[c];
              2'd2: rdata[CNT_W-1:0] = count[c];
              2'd3: rdata[0]         = pend[c];
            endcase
          end
        end
      end
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = pend & ie;

endmodule
